mux_32_1: RTL and testbench
===========================

// Module: mux_32_1
// PURPOSE
//   32:1 single-bit multiplexer with enable and a registered output.
//   Routes one of 32 independent 1-bit data inputs to MUX_Data_Out, chosen by a 5-bit select.
//   Generic datapath leaf used wherever a 1-of-32 bit pick is needed.
//   Has a clean clock-edge timing boundary and a defined reset state.
// PARAMETERS
//   RESET_VALUE  1'b0  value loaded into MUX_Data_Out on reset and while disabled
// PORTS
//   Clock_In      in   1  single system clock; all state updates on rising edge
//   Reset_N_In    in   1  asynchronous, active-low reset
//   Enable_In     in   1  1 = pass selected input; 0 = force output to RESET_VALUE
//   Select_In     in   5  index 0..31 of the input to route
//   Data_0_In     in   1  data input, index 0
//   ...           in   1  Data_1_In .. Data_30_In, one 1-bit port per index
//   Data_31_In    in   1  data input, index 31
//   MUX_Data_Out  out  1  registered selected data
//   Valid_Out     out  1  present only with MUX_32_1_VALID_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset_N_In=0: MUX_Data_Out=RESET_VALUE immediately, with no clock needed.
//     Valid_Out=0 at the same time.
//   - Reset release is synchronised by the user. The first update happens on the
//     first rising edge after Reset_N_In=1.
//   - Each rising edge with Enable_In=1: MUX_Data_Out <= Data_<Select_In>_In.
//     Select_In is an unsigned index; all 32 codes are legal, so there is no out-of-range case.
//   - Each rising edge with Enable_In=0: MUX_Data_Out <= RESET_VALUE.
//     Select_In and data inputs are ignored.
//   - Latency is exactly 1 clock. Inputs are sampled on edge N and appear after edge N.
//   - There is no combinational path from any input to MUX_Data_Out.
//   - Select_In and data may change every cycle. Each edge samples independently and
//     there is no history or hysteresis.
//   - Simultaneous select change and data change in one cycle: the new data at the
//     new index is output after the edge.
//   - Reset asserted mid-stream overrides Enable_In and clocking. The output holds
//     RESET_VALUE until release.
//   - X/Z on Select_In while enabled gives an unspecified output in simulation only.
//     The bench drives known values whenever Enable_In=1.
//     While disabled, X on Select_In or data must not propagate: the output is RESET_VALUE.
//   - Implementation is a 32-way selection (case or index) feeding one flop.
//     No latches are allowed. Every select code is explicitly decoded.
// CONFIGURATION
//   MUX_32_1_VALID_EN defined:
//     - Adds output Valid_Out.
//     - Valid_Out <= Enable_In on each rising edge; 0 on reset.
//     - Valid_Out=1 means MUX_Data_Out holds routed data, not RESET_VALUE.
//   MUX_32_1_VALID_EN undefined:
//     - The Valid_Out port and its flop do not exist.
//     - All other behaviour is identical.
// TESTING
//   1. Reset_N_In=0 mid-cycle with Enable_In=1 and selected data=1
//      -> MUX_Data_Out=0 at once, with no clock edge; Valid_Out=0.
//   2. Enable_In=0, Select_In=X, data=X for 1 edge
//      -> MUX_Data_Out=0 with no X; Valid_Out=0.
//   3. Enable_In=1; walk Select_In 0..31 with only Data_<sel>_In=1 and all others 0
//      -> MUX_Data_Out=1 one edge later for every index.
//   4. Enable_In=1, Select_In=5'd31, Data_31_In=0 and all other inputs=1
//      -> MUX_Data_Out=0 (no neighbour leakage).
//   5. Toggle Enable_In 1,0,1 with Select_In=5'd7, Data_7_In=1
//      -> MUX_Data_Out 1,0,1 on consecutive edges; Valid_Out tracks 1,0,1.
//   6. 20 cycles of random Select_In and random data with Enable_In=1
//      -> each output equals the reference-model pick from the previous edge.

Source files
------------

// File: rtl/mux_32_1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_32_1
//  Description : 32:1 single-bit multiplexer with enable and a registered
//                output. One of 32 independent 1-bit data inputs is routed to
//                MUX_Data_Out one clock after it is sampled. While disabled
//                (or in reset) the output is forced to RESET_VALUE.
//  Options     : MUX_32_1_VALID_EN - when defined, adds Valid_Out, a
//                registered copy of Enable_In marking routed data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_32_1 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic       Clock_In,
    input  logic       Reset_N_In,
    input  logic       Enable_In,
    input  logic [4:0] Select_In,
    input  logic       Data_0_In,
    input  logic       Data_1_In,
    input  logic       Data_2_In,
    input  logic       Data_3_In,
    input  logic       Data_4_In,
    input  logic       Data_5_In,
    input  logic       Data_6_In,
    input  logic       Data_7_In,
    input  logic       Data_8_In,
    input  logic       Data_9_In,
    input  logic       Data_10_In,
    input  logic       Data_11_In,
    input  logic       Data_12_In,
    input  logic       Data_13_In,
    input  logic       Data_14_In,
    input  logic       Data_15_In,
    input  logic       Data_16_In,
    input  logic       Data_17_In,
    input  logic       Data_18_In,
    input  logic       Data_19_In,
    input  logic       Data_20_In,
    input  logic       Data_21_In,
    input  logic       Data_22_In,
    input  logic       Data_23_In,
    input  logic       Data_24_In,
    input  logic       Data_25_In,
    input  logic       Data_26_In,
    input  logic       Data_27_In,
    input  logic       Data_28_In,
    input  logic       Data_29_In,
    input  logic       Data_30_In,
    input  logic       Data_31_In,
`ifdef MUX_32_1_VALID_EN
    output logic       Valid_Out,
`endif
    output logic       MUX_Data_Out
);

    logic w_selected;
    logic r_data;

    // 32-way pick of the addressed input; every code decoded explicitly
    always_comb begin
        w_selected = RESET_VALUE;
        case (Select_In)
            5'd0:    w_selected = Data_0_In;
            5'd1:    w_selected = Data_1_In;
            5'd2:    w_selected = Data_2_In;
            5'd3:    w_selected = Data_3_In;
            5'd4:    w_selected = Data_4_In;
            5'd5:    w_selected = Data_5_In;
            5'd6:    w_selected = Data_6_In;
            5'd7:    w_selected = Data_7_In;
            5'd8:    w_selected = Data_8_In;
            5'd9:    w_selected = Data_9_In;
            5'd10:   w_selected = Data_10_In;
            5'd11:   w_selected = Data_11_In;
            5'd12:   w_selected = Data_12_In;
            5'd13:   w_selected = Data_13_In;
            5'd14:   w_selected = Data_14_In;
            5'd15:   w_selected = Data_15_In;
            5'd16:   w_selected = Data_16_In;
            5'd17:   w_selected = Data_17_In;
            5'd18:   w_selected = Data_18_In;
            5'd19:   w_selected = Data_19_In;
            5'd20:   w_selected = Data_20_In;
            5'd21:   w_selected = Data_21_In;
            5'd22:   w_selected = Data_22_In;
            5'd23:   w_selected = Data_23_In;
            5'd24:   w_selected = Data_24_In;
            5'd25:   w_selected = Data_25_In;
            5'd26:   w_selected = Data_26_In;
            5'd27:   w_selected = Data_27_In;
            5'd28:   w_selected = Data_28_In;
            5'd29:   w_selected = Data_29_In;
            5'd30:   w_selected = Data_30_In;
            5'd31:   w_selected = Data_31_In;
            default: w_selected = RESET_VALUE;
        endcase
    end

    // Output flop: the disable branch never looks at select/data, so X there
    // cannot reach the output while Enable_In is low
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_data <= RESET_VALUE;
        end else if (Enable_In) begin
            r_data <= w_selected;
        end else begin
            r_data <= RESET_VALUE;
        end
    end

    assign MUX_Data_Out = r_data;

`ifdef MUX_32_1_VALID_EN
    logic r_valid;

    // Valid marks cycles where the output carries routed data
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= Enable_In;
        end
    end

    assign Valid_Out = r_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_32_1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_32_1
//  Description : Self-checking bench for mux_32_1 using directed vectors.
//                Valid_Out checks are compiled in with MUX_32_1_VALID_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_32_1;

    logic        r_clk;
    logic        r_rst_n;
    logic        r_en;
    logic [4:0]  r_sel;
    logic [31:0] r_data;
    logic        w_out;
`ifdef MUX_32_1_VALID_EN
    logic        w_valid;
`endif

    int          r_checks;
    int          r_passed;

    mux_32_1 #(.RESET_VALUE(1'b0)) u_dut (
        .Clock_In     (r_clk),
        .Reset_N_In   (r_rst_n),
        .Enable_In    (r_en),
        .Select_In    (r_sel),
        .Data_0_In    (r_data[0]),
        .Data_1_In    (r_data[1]),
        .Data_2_In    (r_data[2]),
        .Data_3_In    (r_data[3]),
        .Data_4_In    (r_data[4]),
        .Data_5_In    (r_data[5]),
        .Data_6_In    (r_data[6]),
        .Data_7_In    (r_data[7]),
        .Data_8_In    (r_data[8]),
        .Data_9_In    (r_data[9]),
        .Data_10_In   (r_data[10]),
        .Data_11_In   (r_data[11]),
        .Data_12_In   (r_data[12]),
        .Data_13_In   (r_data[13]),
        .Data_14_In   (r_data[14]),
        .Data_15_In   (r_data[15]),
        .Data_16_In   (r_data[16]),
        .Data_17_In   (r_data[17]),
        .Data_18_In   (r_data[18]),
        .Data_19_In   (r_data[19]),
        .Data_20_In   (r_data[20]),
        .Data_21_In   (r_data[21]),
        .Data_22_In   (r_data[22]),
        .Data_23_In   (r_data[23]),
        .Data_24_In   (r_data[24]),
        .Data_25_In   (r_data[25]),
        .Data_26_In   (r_data[26]),
        .Data_27_In   (r_data[27]),
        .Data_28_In   (r_data[28]),
        .Data_29_In   (r_data[29]),
        .Data_30_In   (r_data[30]),
        .Data_31_In   (r_data[31]),
`ifdef MUX_32_1_VALID_EN
        .Valid_Out    (w_valid),
`endif
        .MUX_Data_Out (w_out)
    );

    // 10 ns clock
    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic act, input logic exp);
        r_checks = r_checks + 1;
        if (act !== exp)
            $display("FAIL %s: got %b, expected %b", tag, act, exp);
        else
            r_passed = r_passed + 1;
    endtask

    // Advance one rising edge and settle just past it
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    // Directed vectors for the mixed-pattern sweep, expected bits by hand
    logic [4:0]  c_vec_sel  [8];
    logic [31:0] c_vec_data [8];
    logic        c_vec_exp  [8];

    initial begin
        c_vec_sel[0] = 5'd0;  c_vec_data[0] = 32'hA5A5_0F0F; c_vec_exp[0] = 1'b1;
        c_vec_sel[1] = 5'd4;  c_vec_data[1] = 32'hA5A5_0F0F; c_vec_exp[1] = 1'b0;
        c_vec_sel[2] = 5'd8;  c_vec_data[2] = 32'hA5A5_0F0F; c_vec_exp[2] = 1'b1;
        c_vec_sel[3] = 5'd17; c_vec_data[3] = 32'hA5A5_0F0F; c_vec_exp[3] = 1'b0;
        c_vec_sel[4] = 5'd18; c_vec_data[4] = 32'hA5A5_0F0F; c_vec_exp[4] = 1'b1;
        c_vec_sel[5] = 5'd30; c_vec_data[5] = 32'h4000_0000; c_vec_exp[5] = 1'b1;
        c_vec_sel[6] = 5'd29; c_vec_data[6] = 32'h4000_0000; c_vec_exp[6] = 1'b0;
        c_vec_sel[7] = 5'd16; c_vec_data[7] = 32'hFFFE_FFFF; c_vec_exp[7] = 1'b0;
    end

    // Main stimulus sequence
    initial begin
        logic [31:0] v_one_hot;
        logic        v_exp;

        r_checks = 0;
        r_passed = 0;
        r_rst_n  = 1'b0;
        r_en     = 1'b0;
        r_sel    = 5'd0;
        r_data   = 32'h0;

        // Reset state before any clock edge
        #2;
        check("reset_out", w_out, 1'b0);
`ifdef MUX_32_1_VALID_EN
        check("reset_valid", w_valid, 1'b0);
`endif
        // Reset held while enabled and clocking: output stays at reset value
        r_en   = 1'b1;
        r_sel  = 5'd3;
        r_data = 32'hFFFF_FFFF;
        tick();
        tick();
        check("reset_held", w_out, 1'b0);

        // First update lands on the first edge after release
        @(negedge r_clk);
        r_rst_n = 1'b1;
        tick();
        check("first_edge", w_out, 1'b1);
`ifdef MUX_32_1_VALID_EN
        check("first_valid", w_valid, 1'b1);
`endif
        // Async reset mid-cycle, no clock edge needed
        #2;
        r_rst_n = 1'b0;
        #1;
        check("async_reset", w_out, 1'b0);
`ifdef MUX_32_1_VALID_EN
        check("async_valid", w_valid, 1'b0);
`endif
        @(negedge r_clk);
        r_rst_n = 1'b1;

        // Disabled with X select/data: no X reaches the output
        r_en   = 1'b1;
        r_sel  = 5'd1;
        r_data = 32'h0000_0002;
        tick();
        check("pre_dis", w_out, 1'b1);
        r_en   = 1'b0;
        r_sel  = 'x;
        r_data = 'x;
        tick();
        check("dis_x", w_out, 1'b0);
`ifdef MUX_32_1_VALID_EN
        check("dis_x_valid", w_valid, 1'b0);
`endif

        // Walking one across every index
        r_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            v_one_hot    = 32'h0;
            v_one_hot[i] = 1'b1;
            r_sel  = 5'(i);
            r_data = v_one_hot;
            tick();
            check($sformatf("walk1_%0d", i), w_out, 1'b1);
        end

        // Walking zero: selected bit 0, all neighbours 1
        for (int i = 0; i < 32; i++) begin
            v_one_hot    = 32'hFFFF_FFFF;
            v_one_hot[i] = 1'b0;
            r_sel  = 5'(i);
            r_data = v_one_hot;
            tick();
            check($sformatf("walk0_%0d", i), w_out, 1'b0);
        end

        // Top index with all other inputs high
        r_sel  = 5'd31;
        r_data = 32'h7FFF_FFFF;
        tick();
        check("sel31_leak", w_out, 1'b0);

        // Enable toggle 1,0,1 on index 7
        r_sel  = 5'd7;
        r_data = 32'h0000_0080;
        r_en   = 1'b1;
        tick();
        check("tog_1", w_out, 1'b1);
`ifdef MUX_32_1_VALID_EN
        check("tog_v1", w_valid, 1'b1);
`endif
        r_en = 1'b0;
        tick();
        check("tog_0", w_out, 1'b0);
`ifdef MUX_32_1_VALID_EN
        check("tog_v0", w_valid, 1'b0);
`endif
        r_en = 1'b1;
        tick();
        check("tog_1b", w_out, 1'b1);
`ifdef MUX_32_1_VALID_EN
        check("tog_v1b", w_valid, 1'b1);
`endif

        // One-cycle latency: new inputs are not visible before the edge
        r_sel  = 5'd12;
        r_data = 32'h0;
        #2;
        check("no_comb_path", w_out, 1'b1);
        tick();
        check("latency_1", w_out, 1'b0);

        // Mixed directed vectors, select and data changing together
        for (int i = 0; i < 8; i++) begin
            r_sel  = c_vec_sel[i];
            r_data = c_vec_data[i];
            tick();
            check($sformatf("vec_%0d", i), w_out, c_vec_exp[i]);
        end

        // Random select/data, reference pick from the previous edge
        for (int i = 0; i < 20; i++) begin
            r_sel  = 5'($urandom_range(0, 31));
            r_data = $urandom;
            v_exp  = r_data[r_sel];
            tick();
            check($sformatf("rand_%0d", i), w_out, v_exp);
        end

        $display("%0d/%0d checks passed", r_passed, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
